// File: rtl/hit_life_manager_if.sv
// Signal bundle between game control (master) and the life manager (slave).
// The master drives the frame, hit, bonus and start pulses; the slave returns life and status flags.
interface hit_life_manager_if #(
    parameter int LIVES_W = 3
);
    logic               startOfFrame;
    logic               hitPulse;
    logic               lifeBonusPulse;
    logic               startGame;
    logic [LIVES_W-1:0] lives;
    logic               playing;
    logic               invulnerable;
    logic               blinkHide;
    logic               gameOver;
    logic               lifeLostPulse;

    modport master (
        output startOfFrame,
        output hitPulse,
        output lifeBonusPulse,
        output startGame,
        input  lives,
        input  playing,
        input  invulnerable,
        input  blinkHide,
        input  gameOver,
        input  lifeLostPulse
    );

    modport slave (
        input  startOfFrame,
        input  hitPulse,
        input  lifeBonusPulse,
        input  startGame,
        output lives,
        output playing,
        output invulnerable,
        output blinkHide,
        output gameOver,
        output lifeLostPulse
    );
endinterface

// File: rtl/hit_life_manager.sv
// Player life counter with a frame-counted invulnerability window and sprite blink control.
// Hits remove a life and open the window; bonus pickups restore lives up to a ceiling.
module hit_life_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 7,
    parameter int LIVES_W       = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_PERIOD  = 4
) (
    input  logic             clk,
    input  logic             resetN,
    hit_life_manager_if.slave bus
);
    localparam int CNT_W     = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
    localparam int BLINK_BIT = $clog2(BLINK_PERIOD);
    // Wide enough to hold both the incremented count and the blink bit position.
    localparam int NEXT_W    = (CNT_W + 1 > BLINK_BIT + 1) ? CNT_W + 1 : BLINK_BIT + 1;

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_MAX  = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [NEXT_W-1:0]  BLINK_MASK = NEXT_W'(1) << BLINK_BIT;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_INVULN,
        S_OVER
    } state_t;

    state_t             r_state;
    logic [LIVES_W-1:0] r_lives;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               r_playing;
    logic               r_invulnerable;
    logic               r_blink_hide;
    logic               r_game_over;
    logic               r_life_lost;

    logic [LIVES_W-1:0] w_lives_inc;
    logic [LIVES_W-1:0] w_lives_dec;
    logic [NEXT_W-1:0]  w_cnt_next;
    logic               w_blink_next;

    assign w_lives_inc  = (r_lives >= LIVES_MAX) ? LIVES_MAX : r_lives + LIVES_ONE;
    assign w_lives_dec  = (r_lives == '0) ? '0 : r_lives - LIVES_ONE;
    assign w_cnt_next   = NEXT_W'(r_frame_cnt) + NEXT_W'(1);
    assign w_blink_next = |(w_cnt_next & BLINK_MASK);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= S_IDLE;
            r_lives        <= LIVES_INIT;
            r_frame_cnt    <= '0;
            r_playing      <= 1'b0;
            r_invulnerable <= 1'b0;
            r_blink_hide   <= 1'b0;
            r_game_over    <= 1'b0;
            r_life_lost    <= 1'b0;
        end else begin
            r_life_lost <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.startGame) begin
                        r_state   <= S_PLAY;
                        r_lives   <= LIVES_INIT;
                        r_playing <= 1'b1;
                    end
                end

                S_PLAY: begin
                    if (bus.hitPulse) begin
                        r_life_lost <= 1'b1;
                        // A bonus in the same clock cancels the decrement and forbids game over.
                        if (!bus.lifeBonusPulse && r_lives <= LIVES_ONE) begin
                            r_state     <= S_OVER;
                            r_lives     <= '0;
                            r_playing   <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state        <= S_INVULN;
                            r_frame_cnt    <= '0;
                            r_invulnerable <= 1'b1;
                            r_blink_hide   <= 1'b0;
                            if (!bus.lifeBonusPulse) begin
                                r_lives <= w_lives_dec;
                            end
                        end
                    end else if (bus.lifeBonusPulse) begin
                        r_lives <= w_lives_inc;
                    end
                end

                S_INVULN: begin
                    if (bus.lifeBonusPulse) begin
                        r_lives <= w_lives_inc;
                    end
                    if (bus.startOfFrame) begin
                        if (r_frame_cnt == CNT_LAST) begin
                            r_state        <= S_PLAY;
                            r_frame_cnt    <= '0;
                            r_invulnerable <= 1'b0;
                            r_blink_hide   <= 1'b0;
                        end else begin
                            r_frame_cnt  <= w_cnt_next[CNT_W-1:0];
                            r_blink_hide <= w_blink_next;
                        end
                    end
                end

                S_OVER: begin
                    if (bus.startGame) begin
                        r_state     <= S_PLAY;
                        r_lives     <= LIVES_INIT;
                        r_playing   <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.lives         = r_lives;
    assign bus.playing       = r_playing;
    assign bus.invulnerable  = r_invulnerable;
    assign bus.blinkHide     = r_blink_hide;
    assign bus.gameOver      = r_game_over;
    assign bus.lifeLostPulse = r_life_lost;
endmodule

// File: tb/tb_hit_life_manager.sv
// Directed bench for hit_life_manager: a per-cycle behavioural model is compared against the DUT,
// and directed steps also carry hand-computed literal expectations.
module tb_hit_life_manager;
    localparam int INIT_LIVES    = 3;
    localparam int MAX_LIVES     = 7;
    localparam int LIVES_W       = 3;
    localparam int INVULN_FRAMES = 4;
    localparam int BLINK_PERIOD  = 2;

    localparam int P_IDLE   = 0;
    localparam int P_PLAY   = 1;
    localparam int P_INVULN = 2;
    localparam int P_OVER   = 3;

    logic clk;
    logic resetN;

    int n_checks;
    int n_errors;

    // Behavioural model state
    int m_phase;
    int m_lives;
    int m_frames;
    int m_pulse;

    hit_life_manager_if #(.LIVES_W(LIVES_W)) bus ();

    hit_life_manager #(
        .INIT_LIVES   (INIT_LIVES),
        .MAX_LIVES    (MAX_LIVES),
        .LIVES_W      (LIVES_W),
        .INVULN_FRAMES(INVULN_FRAMES),
        .BLINK_PERIOD (BLINK_PERIOD)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v + 1 > MAX_LIVES) ? MAX_LIVES : v + 1;
    endfunction

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_lives  = INIT_LIVES;
        m_frames = 0;
        m_pulse  = 0;
    endtask

    // Game rules applied once per clock to the sampled inputs.
    task automatic model_step();
        if (!resetN) begin
            model_reset();
            return;
        end
        m_pulse = 0;
        case (m_phase)
            P_IDLE: if (bus.startGame) begin
                m_phase = P_PLAY;
                m_lives = INIT_LIVES;
            end
            P_PLAY: begin
                if (bus.hitPulse) begin
                    m_pulse = 1;
                    if (bus.lifeBonusPulse) begin
                        m_phase  = P_INVULN;
                        m_frames = 0;
                    end else if (m_lives <= 1) begin
                        m_lives = 0;
                        m_phase = P_OVER;
                    end else begin
                        m_lives  = m_lives - 1;
                        m_phase  = P_INVULN;
                        m_frames = 0;
                    end
                end else if (bus.lifeBonusPulse) begin
                    m_lives = sat_inc(m_lives);
                end
            end
            P_INVULN: begin
                if (bus.lifeBonusPulse) m_lives = sat_inc(m_lives);
                if (bus.startOfFrame) begin
                    m_frames = m_frames + 1;
                    if (m_frames == INVULN_FRAMES) begin
                        m_phase  = P_PLAY;
                        m_frames = 0;
                    end
                end
            end
            default: if (bus.startGame) begin
                m_phase = P_PLAY;
                m_lives = INIT_LIVES;
            end
        endcase
    endtask

    // Sprite is shown for the first BLINK_PERIOD frames, hidden for the next, and so on.
    function automatic int model_blink();
        if (m_phase != P_INVULN) return 0;
        return ((m_frames / BLINK_PERIOD) % 2 == 1) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        model_step();
        #1;
        chk("cyc lives",         int'(bus.lives),        m_lives);
        chk("cyc playing",       int'(bus.playing),      (m_phase == P_PLAY || m_phase == P_INVULN) ? 1 : 0);
        chk("cyc invulnerable",  int'(bus.invulnerable), (m_phase == P_INVULN) ? 1 : 0);
        chk("cyc gameOver",      int'(bus.gameOver),     (m_phase == P_OVER) ? 1 : 0);
        chk("cyc blinkHide",     int'(bus.blinkHide),    model_blink());
        chk("cyc lifeLostPulse", int'(bus.lifeLostPulse), m_pulse);
    end

    // One clock with the given pulses; returns 3 time units after the edge.
    task automatic cyc(input string tag, input logic sg, input logic hit, input logic bon, input logic sof);
        bus.startGame      = sg;
        bus.hitPulse       = hit;
        bus.lifeBonusPulse = bon;
        bus.startOfFrame   = sof;
        @(posedge clk);
        #3;
        bus.startGame      = 1'b0;
        bus.hitPulse       = 1'b0;
        bus.lifeBonusPulse = 1'b0;
        bus.startOfFrame   = 1'b0;
        $display("[%0t] %-14s sg=%0b hit=%0b bon=%0b sof=%0b -> lives=%0d play=%0b inv=%0b blink=%0b over=%0b lost=%0b",
                 $time, tag, sg, hit, bon, sof, bus.lives, bus.playing, bus.invulnerable,
                 bus.blinkHide, bus.gameOver, bus.lifeLostPulse);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            cyc("frame", 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        int blink_exp [4];
        n_checks = 0;
        n_errors = 0;
        model_reset();
        resetN             = 1'b0;
        bus.startGame      = 1'b0;
        bus.hitPulse       = 1'b0;
        bus.lifeBonusPulse = 1'b0;
        bus.startOfFrame   = 1'b0;
        blink_exp = '{0, 1, 1, 0};

        repeat (2) @(posedge clk);
        #3;
        chk("reset lives",   int'(bus.lives), 3);
        chk("reset playing", int'(bus.playing), 0);
        chk("reset over",    int'(bus.gameOver), 0);
        resetN = 1'b1;

        // Pickups and hits are ignored before the game starts
        cyc("idle bonus", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("idle hit",   1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle lives", int'(bus.lives), 3);

        cyc("start", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("start playing", int'(bus.playing), 1);
        chk("start lives",   int'(bus.lives), 3);
        chk("start inv",     int'(bus.invulnerable), 0);

        cyc("hit1", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hit1 lives", int'(bus.lives), 2);
        chk("hit1 lost",  int'(bus.lifeLostPulse), 1);
        chk("hit1 inv",   int'(bus.invulnerable), 1);
        chk("hit1 blink", int'(bus.blinkHide), 0);
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hit1 lost once", int'(bus.lifeLostPulse), 0);
        cyc("start in inv", 1'b1, 1'b0, 1'b0, 1'b0);

        // Hits on the window frames are ignored; blink pattern 0,1,1 then exit at 0
        for (int f = 0; f < 4; f++) begin
            cyc("inv frame+hit", 1'b0, 1'b1, 1'b0, 1'b1);
            chk("inv lives", int'(bus.lives), 2);
            chk("inv blink", int'(bus.blinkHide), blink_exp[f]);
            chk("inv lost",  int'(bus.lifeLostPulse), 0);
        end
        chk("inv exit", int'(bus.invulnerable), 0);
        chk("inv exit playing", int'(bus.playing), 1);

        cyc("start in play", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("start ignored lives", int'(bus.lives), 2);

        // Hit coinciding with a frame pulse is still processed
        cyc("hit2+frame", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("hit2 lives", int'(bus.lives), 1);
        chk("hit2 lost",  int'(bus.lifeLostPulse), 1);
        frames(4);
        cyc("hit3", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hit3 lives",   int'(bus.lives), 0);
        chk("hit3 over",    int'(bus.gameOver), 1);
        chk("hit3 playing", int'(bus.playing), 0);
        cyc("over hit+bon", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("over lives", int'(bus.lives), 0);
        cyc("restart", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart lives", int'(bus.lives), 3);
        chk("restart over",  int'(bus.gameOver), 0);

        for (int b = 0; b < 5; b++) begin
            cyc("bonus", 1'b0, 1'b0, 1'b1, 1'b0);
            chk("bonus lives", int'(bus.lives), (b < 4) ? 4 + b : 7);
        end

        // Walk down to one life, then hit and bonus together
        cyc("hit", 1'b0, 1'b1, 1'b0, 1'b0);
        frames(4);
        for (int k = 0; k < 5; k++) begin
            cyc("hit", 1'b0, 1'b1, 1'b0, 1'b0);
            frames(4);
        end
        chk("walk lives", int'(bus.lives), 1);
        cyc("hit+bonus", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("hb lives", int'(bus.lives), 1);
        chk("hb inv",   int'(bus.invulnerable), 1);
        chk("hb lost",  int'(bus.lifeLostPulse), 1);
        chk("hb over",  int'(bus.gameOver), 0);
        cyc("inv bonus", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("inv bonus lives", int'(bus.lives), 2);
        frames(2);

        // Asynchronous reset mid-window
        resetN = 1'b0;
        #1;
        chk("areset lives",   int'(bus.lives), 3);
        chk("areset inv",     int'(bus.invulnerable), 0);
        chk("areset playing", int'(bus.playing), 0);
        chk("areset blink",   int'(bus.blinkHide), 0);
        @(posedge clk);
        #3;
        resetN = 1'b1;
        cyc("post-reset hit", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post-reset lives", int'(bus.lives), 3);
        chk("post-reset lost",  int'(bus.lifeLostPulse), 0);
        cyc("start", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("final playing", int'(bus.playing), 1);
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
